plp_bus_arbiter_n: RTL and testbench
====================================

// Module: plp_bus_arbiter_n
// PURPOSE
// - Parametrised CPU-to-peripheral bus arbiter for the PLP SoC. It replaces the fixed-map arbiter.
// - Serialises each CPU step into an optional data access, then an instruction fetch, over one shared slave bus.
// - Decodes each access to one of NUM_SLAVES address windows and stalls the CPU until the selected slave is ready.
// - Times out hung or unmapped accesses and aggregates edge-triggered interrupts onto int/int_ack.
// PARAMETERS
// - NUM_SLAVES  8        number of slave windows (1..16)
// - ADDR_W      32       address width
// - DATA_W      32       data width
// - SLV_BASE    {..}     NUM_SLAVES*ADDR_W packed window bases; slave k at [k*ADDR_W +: ADDR_W]
// - SLV_MASK    {..}     packed masks; a hit is (addr & MASK_k) == BASE_k
// - TIMEOUT     255      maximum wait cycles per access before forced completion (>=1)
// - NUM_IRQ     8        interrupt source count
// PORTS
// - clk          in   1                   system clock; all state on rising edge
// - rst          in   1                   synchronous active-high reset
// - iaddr        in   ADDR_W              CPU fetch address
// - daddr        in   ADDR_W              CPU data address
// - dout         in   DATA_W              CPU store data
// - drw          in   2                   [1]=read, [0]=write; 00=no data access; 11 treated as write
// - iin          out  DATA_W              fetched instruction, registered
// - din          out  DATA_W              load data, registered
// - cpu_stall    out  1                   CPU holds all outputs while 1
// - int          out  1                   interrupt request to CPU
// - int_ack      in   1                   CPU acknowledge; 1-cycle pulse
// - s_addr       out  ADDR_W              shared slave address
// - s_wdata      out  DATA_W              shared slave write data
// - s_rd, s_wr   out  1                   read/write strobes, held until ready
// - s_sel        out  NUM_SLAVES          one-hot slave select
// - s_rdata      in   NUM_SLAVES*DATA_W   packed slave read data
// - s_ready      in   NUM_SLAVES          per-slave completion; sampled only when selected
// - irq_in       in   NUM_IRQ             interrupt sources, level, synchronous to clk
// - irq_pending  out  NUM_IRQ             latched pending vector, for a status slave
// - bus_err      out  1                   sticky: unmapped or timed-out access seen
// - err_addr     out  ADDR_W              address of the most recent error
// BEHAVIOUR
// - FSM IDLE -> DATA (drw!=0) or FETCH (drw==0); DATA -> FETCH on done; FETCH -> DONE on done; DONE -> IDLE.
// - cpu_stall = (state != DONE). The CPU advances exactly once per DONE cycle.
// - Zero-wait slaves give 3 cycles per fetch-only step and 4 per step with a data access.
// - DATA state: s_addr=daddr; s_wr=drw[0], else s_rd=1; s_wdata=dout.
// - FETCH state: s_addr=iaddr, s_rd=1.
// - IDLE and DONE: s_rd=s_wr=0, s_sel=0.
// - Decode: lowest-index matching window wins. No match -> done in the same cycle.
//   On no match, read data = 0, bus_err<=1, err_addr<=addr, and no strobe is issued.
// - done = s_ready[sel] or wait_cnt==TIMEOUT. wait_cnt clears on state entry and saturates at TIMEOUT.
// - Timeout completion: read data = {DATA_W{1'b1}}, bus_err<=1, err_addr<=addr.
// - Read data is captured into din or iin on the done edge.
//   din keeps its value when drw has no read; iin/din hold while the FSM is in IDLE.
// - A slave whose ready arrives after a timeout is ignored; the next access re-decodes.
// - Interrupts: pending[i] <= 1 on a rising edge of irq_in[i]; int = |pending.
// - int_ack clears every bit pending before the ack edge.
//   A rising edge in the same cycle as int_ack stays pending, and int stays 1.
// - Reset values: state=IDLE, cpu_stall=1, iin=din=0, s_*=0, pending=0, bus_err=0, err_addr=0,
//   irq_in history=0, int=0.
// - Reset mid-access: strobes drop on the next edge, the access is abandoned, and the CPU must reissue.
// STRUCTURE
// - plp_bus_pkg holds the FSM state encoding, the DRW_READ/DRW_WRITE bit indices and TIMEOUT_RDATA.
// - Sub-module plp_addr_decode: combinational priority window match.
//   Outputs: one-hot sel, sel_idx, hit.
// - Arbiter body: FSM, wait counter, read-data mux, error capture and interrupt latch.
// TESTING
// - Reset test: hold rst for 3 cycles.
//   Expect cpu_stall=1, int=0 and bus_err=0. After release, the first DONE comes 3 cycles later.
// - Load test: drw=10, daddr in slave 2, slave 2 ready after 2 waits with rdata=32'h1234_5678.
//   Expect din=32'h1234_5678, then a fetch, and cpu_stall=0 only in the DONE cycle.
// - Store test: drw=01, dout=32'hA5A5_A5A5.
//   Expect s_wr=1, s_wdata=32'hA5A5_A5A5 and s_sel one-hot, held until ready; no din change.
// - Timeout test: TIMEOUT=4 and the selected slave never ready.
//   Expect completion after 5 cycles in FETCH, iin=32'hFFFF_FFFF, bus_err=1 and err_addr=iaddr.
// - Unmapped test: access address 32'hF000_0000.
//   Expect no strobe, din=0, bus_err=1, and the FSM advancing the next cycle.
// - Interrupt test: pulse irq_in[3], then assert int_ack in the same cycle as an irq_in[5] rise.
//   Expect int=1, then pending=8'h20 and int still 1.

Source files
------------

// File: rtl/plp_bus_arbiter_n_pkg.sv
// plp_bus_pkg: shared FSM encoding, drw bit positions and timeout read pattern for the PLP bus arbiter
package plp_bus_pkg;
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_DATA  = 2'd1;
    localparam logic [1:0] ST_FETCH = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;
    localparam int DRW_READ  = 1;
    localparam int DRW_WRITE = 0;
    localparam logic [127:0] TIMEOUT_RDATA = '1;
endpackage

// File: rtl/plp_bus_arbiter_n_if.sv
// plp_bus_arbiter_n_if: shared slave bus between the arbiter (master) and its peripherals
interface plp_bus_arbiter_n_if #(
    parameter int NUM_SLAVES = 8,
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32
);
    logic [ADDR_W-1:0]            s_addr;
    logic [DATA_W-1:0]            s_wdata;
    logic                         s_rd;
    logic                         s_wr;
    logic [NUM_SLAVES-1:0]        s_sel;
    logic [NUM_SLAVES*DATA_W-1:0] s_rdata;
    logic [NUM_SLAVES-1:0]        s_ready;
    modport master (output s_addr, s_wdata, s_rd, s_wr, s_sel, input s_rdata, s_ready);
    modport slave (input s_addr, s_wdata, s_rd, s_wr, s_sel, output s_rdata, s_ready);
endinterface

// File: rtl/plp_bus_arbiter_n_addr_decode.sv
// plp_addr_decode: combinational priority window match, lowest-index window wins
module plp_addr_decode #(
    parameter int NUM_SLAVES = 8,
    parameter int ADDR_W     = 32,
    parameter int IW         = 3,
    parameter logic [NUM_SLAVES*ADDR_W-1:0] SLV_BASE = '0,
    parameter logic [NUM_SLAVES*ADDR_W-1:0] SLV_MASK = '0
) (
    input  logic [ADDR_W-1:0]     addr,
    output logic [NUM_SLAVES-1:0] sel,
    output logic [IW-1:0]         sel_idx,
    output logic                  hit
);
    always_comb begin
        sel_idx = '0;
        hit = 1'b0;
        for (int k = NUM_SLAVES - 1; k >= 0; k--)
            if ((addr & SLV_MASK[k*ADDR_W +: ADDR_W]) == SLV_BASE[k*ADDR_W +: ADDR_W]) begin
                sel_idx = IW'(k);
                hit = 1'b1;
            end
    end
    assign sel = hit ? NUM_SLAVES'(1) << sel_idx : '0;
endmodule

// File: rtl/plp_bus_arbiter_n.sv
// plp_bus_arbiter_n: serialises each CPU step into data access then fetch over one shared slave bus,
// with window decode, per-access timeout, sticky error capture and edge-triggered interrupt latch
module plp_bus_arbiter_n
    import plp_bus_pkg::*;
#(
    parameter int NUM_SLAVES = 8,
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter logic [NUM_SLAVES*ADDR_W-1:0] SLV_BASE = {
        32'h0700_0000, 32'h0600_0000, 32'h0500_0000, 32'h0400_0000,
        32'h0300_0000, 32'h0200_0000, 32'h0100_0000, 32'h0000_0000},
    parameter logic [NUM_SLAVES*ADDR_W-1:0] SLV_MASK = {8{32'hFF00_0000}},
    parameter int TIMEOUT    = 255,
    parameter int NUM_IRQ    = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ADDR_W-1:0]   iaddr,
    input  logic [ADDR_W-1:0]   daddr,
    input  logic [DATA_W-1:0]   dout,
    input  logic [1:0]          drw,
    output logic [DATA_W-1:0]   iin,
    output logic [DATA_W-1:0]   din,
    output logic                cpu_stall,
    output logic                int_req,
    input  logic                int_ack,
    plp_bus_arbiter_n_if.master bus,
    input  logic [NUM_IRQ-1:0]  irq_in,
    output logic [NUM_IRQ-1:0]  irq_pending,
    output logic                bus_err,
    output logic [ADDR_W-1:0]   err_addr
);
    localparam int IW = NUM_SLAVES > 1 ? $clog2(NUM_SLAVES) : 1;
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [1:0] state, state_nxt;
    logic [CW-1:0] wait_cnt;
    logic [NUM_SLAVES-1:0] sel;
    logic [IW-1:0] sel_idx;
    logic hit, is_data, act, rdy, tmo, done;
    logic [DATA_W-1:0] rdata;
    logic [NUM_IRQ-1:0] irq_q, rise;
    assign is_data = state == ST_DATA;
    assign act = is_data || state == ST_FETCH;
    assign bus.s_addr = is_data ? daddr : state == ST_FETCH ? iaddr : '0;
    assign bus.s_wdata = is_data ? dout : '0;
    plp_addr_decode #(
        .NUM_SLAVES(NUM_SLAVES), .ADDR_W(ADDR_W), .IW(IW),
        .SLV_BASE(SLV_BASE), .SLV_MASK(SLV_MASK)
    ) u_decode (.addr(bus.s_addr), .sel(sel), .sel_idx(sel_idx), .hit(hit));
    // unmapped accesses issue no strobe and complete immediately
    assign bus.s_wr = is_data && hit && drw[DRW_WRITE];
    assign bus.s_rd = act && hit && !(is_data && drw[DRW_WRITE]);
    assign bus.s_sel = act ? sel : '0;
    assign rdy = hit && bus.s_ready[sel_idx];
    assign tmo = wait_cnt == CW'(TIMEOUT);
    assign done = !hit || rdy || tmo;
    assign rdata = !hit ? '0 : rdy ? bus.s_rdata[sel_idx*DATA_W +: DATA_W] : TIMEOUT_RDATA[DATA_W-1:0];
    assign cpu_stall = state != ST_DONE;
    assign int_req = |irq_pending;
    assign rise = irq_in & ~irq_q;
    always_comb
        state_nxt = state == ST_IDLE  ? (drw != 2'b00 ? ST_DATA : ST_FETCH) :
                    state == ST_DATA  ? (done ? ST_FETCH : ST_DATA) :
                    state == ST_FETCH ? (done ? ST_DONE : ST_FETCH) : ST_IDLE;
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            wait_cnt    <= '0;
            iin         <= '0;
            din         <= '0;
            bus_err     <= 1'b0;
            err_addr    <= '0;
            irq_q       <= '0;
            irq_pending <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= state_nxt != state ? '0 : tmo ? wait_cnt : wait_cnt + 1'b1;
            if (state == ST_FETCH && done)
                iin <= rdata;
            if (is_data && done && drw[DRW_READ] && !drw[DRW_WRITE])
                din <= rdata;
            if (act && done && !rdy) begin
                bus_err  <= 1'b1;
                err_addr <= bus.s_addr;
            end
            irq_q       <= irq_in;
            // sources rising in the ack cycle survive the clear
            irq_pending <= (int_ack ? '0 : irq_pending) | rise;
        end
    end
endmodule

// File: tb/tb_plp_bus_arbiter_n.sv
// tb_plp_bus_arbiter_n: directed scoreboard bench for plp_bus_arbiter_n with a programmable-latency slave model
module tb_plp_bus_arbiter_n;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] iaddr = '0, daddr = '0, dout = '0;
    logic [1:0]  drw = 2'b00;
    logic        int_ack = 1'b0;
    logic [7:0]  irq_in = '0;
    logic [31:0] iin, din, err_addr;
    logic        cpu_stall, int_req, bus_err;
    logic [7:0]  irq_pending;
    int          dly[8];
    logic [31:0] sdata[8];
    int          wcnt = 0;
    int          nvec = 0, nerr = 0, cyc = 0;
    typedef struct {
        logic [31:0] iin;
        logic [31:0] din;
        logic [31:0] ea;
        logic        err;
        int          cyc;
    } exp_t;
    exp_t sb[$];

    plp_bus_arbiter_n_if #(.NUM_SLAVES(8), .ADDR_W(32), .DATA_W(32)) bus ();

    plp_bus_arbiter_n #(.TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .iaddr(iaddr), .daddr(daddr), .dout(dout), .drw(drw),
        .iin(iin), .din(din), .cpu_stall(cpu_stall), .int_req(int_req), .int_ack(int_ack),
        .bus(bus), .irq_in(irq_in), .irq_pending(irq_pending), .bus_err(bus_err), .err_addr(err_addr)
    );

    always #5 clk = ~clk;

    // slave k answers once it has seen dly[k] wait cycles; negative latency means never
    always_comb begin
        for (int k = 0; k < 8; k++) begin
            bus.s_ready[k] = bus.s_sel[k] && dly[k] >= 0 && wcnt >= dly[k];
            bus.s_rdata[k*32 +: 32] = sdata[k];
        end
    end
    always @(posedge clk) wcnt <= ((bus.s_rd || bus.s_wr) && !(|bus.s_ready)) ? wcnt + 1 : 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
    endtask

    task automatic start(input logic [31:0] ia, input logic [31:0] da, input logic [31:0] dw,
                         input logic [1:0] rw, input logic [31:0] e_iin, input logic [31:0] e_din,
                         input logic e_err, input logic [31:0] e_ea, input int e_cyc);
        iaddr = ia;
        daddr = da;
        dout  = dw;
        drw   = rw;
        sb.push_back('{iin: e_iin, din: e_din, ea: e_ea, err: e_err, cyc: e_cyc});
        cyc = 1;
    endtask

    task automatic finish(input string tag);
        exp_t e;
        while (cpu_stall && cyc < 60) tick();
        e = sb.pop_front();
        check({tag, " cycles"}, 32'(cyc), 32'(e.cyc));
        check({tag, " iin"}, iin, e.iin);
        check({tag, " din"}, din, e.din);
        check({tag, " bus_err"}, 32'(bus_err), 32'(e.err));
        check({tag, " err_addr"}, err_addr, e.ea);
        tick();
        check({tag, " stall after done"}, 32'(cpu_stall), 32'd1);
    endtask

    initial begin
        for (int k = 0; k < 8; k++) begin
            dly[k] = 0;
            sdata[k] = 32'hC0DE_0000 | k;
        end
        sdata[2] = 32'h1234_5678;
        dly[5] = -1;
        repeat (3) @(negedge clk);
        check("reset stall", 32'(cpu_stall), 32'd1);
        check("reset int", 32'(int_req), 32'd0);
        check("reset bus_err", 32'(bus_err), 32'd0);
        check("reset err_addr", err_addr, 32'd0);
        check("reset iin", iin, 32'd0);
        check("reset din", din, 32'd0);
        check("reset strobes", {30'd0, bus.s_rd, bus.s_wr}, 32'd0);
        check("reset sel", 32'(bus.s_sel), 32'd0);
        check("reset pending", 32'(irq_pending), 32'd0);
        rst = 1'b0;
        start(32'h0000_0100, 32'h0, 32'h0, 2'b00, 32'hC0DE_0000, 32'h0, 1'b0, 32'h0, 3);
        finish("first fetch");
        dly[2] = 2;
        start(32'h0100_0104, 32'h0200_0010, 32'h0, 2'b10, 32'hC0DE_0001, 32'h1234_5678, 1'b0, 32'h0, 6);
        finish("load");
        dly[3] = 2;
        start(32'h0000_0108, 32'h0300_0020, 32'hA5A5_A5A5, 2'b01, 32'hC0DE_0000, 32'h1234_5678, 1'b0, 32'h0, 6);
        tick();
        check("store s_wr", 32'(bus.s_wr), 32'd1);
        check("store s_rd", 32'(bus.s_rd), 32'd0);
        check("store s_wdata", bus.s_wdata, 32'hA5A5_A5A5);
        check("store s_addr", bus.s_addr, 32'h0300_0020);
        check("store s_sel", 32'(bus.s_sel), 32'h08);
        tick();
        check("store s_wr held", 32'(bus.s_wr), 32'd1);
        check("store s_sel held", 32'(bus.s_sel), 32'h08);
        finish("store");
        start(32'h0600_010C, 32'h0400_0030, 32'h0, 2'b11, 32'hC0DE_0006, 32'h1234_5678, 1'b0, 32'h0, 4);
        tick();
        check("drw11 s_wr", 32'(bus.s_wr), 32'd1);
        check("drw11 s_rd", 32'(bus.s_rd), 32'd0);
        finish("drw11 store");
        start(32'h0000_0110, 32'hF000_0000, 32'h0, 2'b10, 32'hC0DE_0000, 32'h0, 1'b1, 32'hF000_0000, 4);
        tick();
        check("unmapped strobes", {30'd0, bus.s_rd, bus.s_wr}, 32'd0);
        check("unmapped sel", 32'(bus.s_sel), 32'd0);
        finish("unmapped");
        start(32'h0500_0040, 32'h0, 32'h0, 2'b00, 32'hFFFF_FFFF, 32'h0, 1'b1, 32'h0500_0040, 7);
        finish("timeout");
        start(32'h0000_0114, 32'h0, 32'h0, 2'b00, 32'hC0DE_0000, 32'h0, 1'b1, 32'h0500_0040, 3);
        finish("redecode");
        drw = 2'b10;
        daddr = 32'h0500_0050;
        tick();
        check("abort s_rd", 32'(bus.s_rd), 32'd1);
        rst = 1'b1;
        tick();
        check("abort s_rd dropped", 32'(bus.s_rd), 32'd0);
        check("abort stall", 32'(cpu_stall), 32'd1);
        check("abort bus_err", 32'(bus_err), 32'd0);
        rst = 1'b0;
        start(32'h0000_0118, 32'h0, 32'h0, 2'b00, 32'hC0DE_0000, 32'h0, 1'b0, 32'h0, 3);
        finish("after abort");
        irq_in = 8'h08;
        tick();
        irq_in = 8'h00;
        check("irq3 int", 32'(int_req), 32'd1);
        check("irq3 pending", 32'(irq_pending), 32'h08);
        tick();
        check("irq3 held", 32'(irq_pending), 32'h08);
        irq_in = 8'h20;
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
        check("ack+irq5 pending", 32'(irq_pending), 32'h20);
        check("ack+irq5 int", 32'(int_req), 32'd1);
        tick();
        check("irq5 level no retrigger", 32'(irq_pending), 32'h20);
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
        check("final ack pending", 32'(irq_pending), 32'h00);
        check("final ack int", 32'(int_req), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
